// File: rtl/clock_pkg.sv
// Shared state encoding, field limits and wrap arithmetic for the clock
// time-setting path.
package clock_pkg;

   typedef enum logic [2:0] {
      RUN         = 3'd0,
      SET_HOURS   = 3'd1,
      SET_MINUTES = 3'd2,
      SET_SECONDS = 3'd3
   } state_t;

   localparam logic [5:0] HOURS_MAX  = 6'd23;
   localparam logic [5:0] MINSEC_MAX = 6'd59;

   // +/-1 on a field that wraps between 0 and max, done at field width.
   function automatic logic [5:0] wrap_step(input logic [5:0] val,
                                            input logic [5:0] max,
                                            input logic       up);
      if (up) return (val >= max) ? 6'd0 : val + 6'd1;
      else    return (val == 6'd0) ? max : val - 6'd1;
   endfunction

endpackage

// File: rtl/button_repeat.sv
// Press edge detect plus hold/auto-repeat event generator for one button.
module button_repeat #(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic i_level,
   output logic o_event
);
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
   // Reloading here makes every later repeat land REPEAT_CYCLES apart.
   localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - REPEAT_CYCLES + 1);

   logic          r_prev;
   logic          r_evt;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_prev <= 1'b0;
         r_evt  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_prev <= i_level;
         r_evt  <= 1'b0;
         if (!i_level) begin
            r_cnt <= '0;
         end else if (!r_prev) begin
            r_evt <= 1'b1;
            r_cnt <= CW'(1);
         end else if (r_cnt == HOLD_C) begin
            r_evt <= 1'b1;
            r_cnt <= RELOAD;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_event = r_evt;

endmodule

// File: rtl/clock_set_controller.sv
// Time-setting sequencer: edits a shadow HH:MM:SS, gates the seconds
// counter while editing and commits with a one-cycle load strobe.
module clock_set_controller
   import clock_pkg::*;
#(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int TIMEOUT_S     = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pulse_1hz,
   input  logic       mode_button,
   input  logic       add_button,
   input  logic       sub_button,
   input  logic [4:0] cur_hours,
   input  logic [5:0] cur_minutes,
   input  logic [5:0] cur_seconds,
   output logic       run_enable,
   output logic       load_time,
   output logic [4:0] set_hours,
   output logic [5:0] set_minutes,
   output logic [5:0] set_seconds,
   output logic [1:0] edit_field,
   output logic       blink_on
);
   localparam int IW = $clog2(TIMEOUT_S + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);

   state_t        r_state, w_nxt;
   logic          r_mode_prev, r_mode_evt;
   logic          w_add, w_sub, w_set, w_edit, w_timeout;
   logic          r_run, r_load, r_blink;
   logic [1:0]    r_field;
   logic [4:0]    r_hours;
   logic [5:0]    r_minutes, r_seconds;
   logic [IW-1:0] r_idle;
   logic [5:0]    w_fval, w_fmax, w_fnew;

   button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_add (
      .clock(clock), .reset(reset), .i_level(add_button), .o_event(w_add));

   button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_sub (
      .clock(clock), .reset(reset), .i_level(sub_button), .o_event(w_sub));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mode_prev <= 1'b0;
         r_mode_evt  <= 1'b0;
      end else begin
         r_mode_prev <= mode_button;
         r_mode_evt  <= mode_button & ~r_mode_prev;
      end
   end

   assign w_set     = (r_state != RUN);
   // mode beats add/sub; opposing add and sub cancel out.
   assign w_edit    = w_set & ~r_mode_evt & (w_add ^ w_sub);
   assign w_timeout = w_set & ~r_mode_evt & ~w_add & ~w_sub & pulse_1hz & (r_idle == IDLE_LAST);

   always_comb begin
      w_nxt = r_state;
      if (r_mode_evt) begin
         case (r_state)
            RUN:         w_nxt = SET_HOURS;
            SET_HOURS:   w_nxt = SET_MINUTES;
            SET_MINUTES: w_nxt = SET_SECONDS;
            default:     w_nxt = RUN;
         endcase
      end else if (w_timeout) begin
         w_nxt = RUN;
      end
   end

   always_comb begin
      w_fval = {1'b0, r_hours};
      w_fmax = HOURS_MAX;
      case (r_state)
         SET_MINUTES: begin w_fval = r_minutes; w_fmax = MINSEC_MAX; end
         SET_SECONDS: begin w_fval = r_seconds; w_fmax = MINSEC_MAX; end
         default: ;
      endcase
   end

   assign w_fnew = wrap_step(w_fval, w_fmax, w_add);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= RUN;
         r_run     <= 1'b1;
         r_field   <= 2'd0;
         r_load    <= 1'b0;
         r_blink   <= 1'b1;
         r_idle    <= '0;
         r_hours   <= '0;
         r_minutes <= '0;
         r_seconds <= '0;
      end else begin
         r_state <= w_nxt;
         r_run   <= (w_nxt == RUN);
         r_field <= w_nxt[1:0];
         // A timeout exit never loads, only the mode exit from seconds does.
         r_load  <= r_mode_evt & (r_state == SET_SECONDS);

         if (r_mode_evt && r_state == RUN) begin
            r_hours   <= cur_hours;
            r_minutes <= cur_minutes;
            r_seconds <= cur_seconds;
         end else if (w_edit) begin
            case (r_state)
               SET_HOURS:   r_hours   <= w_fnew[4:0];
               SET_MINUTES: r_minutes <= w_fnew;
               default:     r_seconds <= w_fnew;
            endcase
         end

         if (w_nxt == RUN || r_mode_evt || w_add || w_sub) r_idle <= '0;
         else if (pulse_1hz)                               r_idle <= r_idle + IW'(1);

         if (w_nxt == RUN)                            r_blink <= 1'b1;
         else if ((w_add | w_sub) & ~r_mode_evt)      r_blink <= 1'b1;
         else if (pulse_1hz)                          r_blink <= ~r_blink;
      end
   end

   assign run_enable  = r_run;
   assign load_time   = r_load;
   assign edit_field  = r_field;
   assign blink_on    = r_blink;
   assign set_hours   = r_hours;
   assign set_minutes = r_minutes;
   assign set_seconds = r_seconds;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: vector table, hand-written multi-cycle
// sequences and random traffic against a behavioural model.
module tb_clock_set_controller;
   localparam int HOLD = 8;
   localparam int REP  = 4;
   localparam int TOUT = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       pulse_1hz = 1'b0, mode_button = 1'b0, add_button = 1'b0, sub_button = 1'b0;
   logic [4:0] cur_hours = '0;
   logic [5:0] cur_minutes = '0, cur_seconds = '0;
   logic       run_enable, load_time, blink_on;
   logic [4:0] set_hours;
   logic [5:0] set_minutes, set_seconds;
   logic [1:0] edit_field;

   int checks = 0;
   int errors = 0;

   clock_set_controller #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .TIMEOUT_S(TOUT)) dut (
      .clock(clock), .reset(reset), .pulse_1hz(pulse_1hz),
      .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
      .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
      .run_enable(run_enable), .load_time(load_time),
      .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
      .edit_field(edit_field), .blink_on(blink_on));

   always #5 clock = ~clock;

   // Behavioural model: state number 0..3, fields as integers with modulo wrap.
   int m_st, m_h, m_mi, m_s, m_idle, na, ns;
   bit m_load, m_blink, pm, pa, ps, mprev;

   function automatic void model_reset();
      m_st = 0; m_h = 0; m_mi = 0; m_s = 0; m_idle = 0;
      m_load = 0; m_blink = 1; pm = 0; pa = 0; ps = 0; mprev = 0; na = -1; ns = -1;
   endfunction

   function automatic bit repeat_due(int n);
      return (n == 0) || (n >= HOLD && ((n - HOLD) % REP) == 0);
   endfunction

   function automatic void model_step();
      int st;
      st = m_st;
      m_load = 0;
      if (pm) begin
         if (st == 0) begin m_h = cur_hours; m_mi = cur_minutes; m_s = cur_seconds; end
         if (st == 3) m_load = 1;
         st = (st + 1) % 4;
         m_idle = 0;
      end else if (st != 0 && (pa || ps)) begin
         m_idle = 0;
         if (pa != ps) begin
            if (st == 1) m_h  = (m_h  + (pa ? 1 : 23)) % 24;
            if (st == 2) m_mi = (m_mi + (pa ? 1 : 59)) % 60;
            if (st == 3) m_s  = (m_s  + (pa ? 1 : 59)) % 60;
         end
      end else if (st != 0 && pulse_1hz) begin
         m_idle++;
         if (m_idle == TOUT) begin st = 0; m_idle = 0; end
      end
      if (st == 0)                  m_blink = 1;
      else if (!pm && (pa || ps))   m_blink = 1;
      else if (pulse_1hz)           m_blink = !m_blink;
      m_st = st;
      // Events sampled at this edge are visible to the next one.
      pm = mode_button && !mprev;
      mprev = mode_button;
      if (!add_button) na = -1; else na++;
      if (!sub_button) ns = -1; else ns++;
      pa = add_button && repeat_due(na);
      ps = sub_button && repeat_due(ns);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock); #1;
      model_step();
   endtask

   task automatic press(input bit m, input bit a, input bit s);
      mode_button = m; add_button = a; sub_button = s;
      step();
      mode_button = 0; add_button = 0; sub_button = 0;
      step();
   endtask

   task automatic do_reset();
      mode_button = 0; add_button = 0; sub_button = 0; pulse_1hz = 0;
      reset = 0;
      model_reset();
      repeat (2) @(posedge clock);
      #1 reset = 1;
   endtask

   typedef struct {
      bit m; bit a; bit s;
      int ch; int cm; int cs;
      int f; int h; int mi; int sc; bit ld;
   } vec_t;
   vec_t tbl[20];

   bit busy;
   int lim, loads;

   initial begin
      tbl[0]  = '{1,0,0, 12,34,56, 1,12,34,56,0};
      tbl[1]  = '{0,1,0, 12,34,56, 1,13,34,56,0};
      tbl[2]  = '{0,0,1, 12,34,56, 1,12,34,56,0};
      tbl[3]  = '{0,0,1, 12,34,56, 1,11,34,56,0};
      tbl[4]  = '{0,1,1, 12,34,56, 1,11,34,56,0};
      tbl[5]  = '{1,1,0, 12,34,56, 2,11,34,56,0};
      tbl[6]  = '{0,1,0, 12,34,56, 2,11,35,56,0};
      tbl[7]  = '{1,0,0, 12,34,56, 3,11,35,56,0};
      tbl[8]  = '{0,0,1, 12,34,56, 3,11,35,55,0};
      tbl[9]  = '{1,0,0, 12,34,56, 0,11,35,55,1};
      tbl[10] = '{0,1,0, 12,34,56, 0,11,35,55,0};
      tbl[11] = '{1,0,0, 23, 0, 0, 1,23, 0, 0,0};
      tbl[12] = '{0,1,0, 23, 0, 0, 1, 0, 0, 0,0};
      tbl[13] = '{0,0,1, 23, 0, 0, 1,23, 0, 0,0};
      tbl[14] = '{1,0,0, 23, 0, 0, 2,23, 0, 0,0};
      tbl[15] = '{0,0,1, 23, 0, 0, 2,23,59, 0,0};
      tbl[16] = '{1,0,0, 23, 0, 0, 3,23,59, 0,0};
      tbl[17] = '{0,0,1, 23, 0, 0, 3,23,59,59,0};
      tbl[18] = '{0,1,0, 23, 0, 0, 3,23,59, 0,0};
      tbl[19] = '{1,0,0, 23, 0, 0, 0,23,59, 0,1};

      do_reset();
      chk("rst_run", run_enable, 1);
      chk("rst_load", load_time, 0);
      chk("rst_field", edit_field, 0);
      chk("rst_blink", blink_on, 1);
      chk("rst_set", {set_hours, set_minutes, set_seconds}, 0);

      for (int i = 0; i < 20; i++) begin
         cur_hours = 5'(tbl[i].ch); cur_minutes = 6'(tbl[i].cm); cur_seconds = 6'(tbl[i].cs);
         press(tbl[i].m, tbl[i].a, tbl[i].s);
         chk($sformatf("vec%0d_field", i), edit_field, tbl[i].f);
         chk($sformatf("vec%0d_run", i), run_enable, tbl[i].f == 0);
         chk($sformatf("vec%0d_load", i), load_time, tbl[i].ld);
         chk($sformatf("vec%0d_h", i), set_hours, tbl[i].h);
         chk($sformatf("vec%0d_m", i), set_minutes, tbl[i].mi);
         chk($sformatf("vec%0d_s", i), set_seconds, tbl[i].sc);
      end

      // Auto-repeat: hold add for 20 cycles in SET_SECONDS from 10.
      do_reset();
      cur_hours = 0; cur_minutes = 0; cur_seconds = 10;
      repeat (3) press(1, 0, 0);
      chk("hold_field", edit_field, 3);
      chk("hold_start", set_seconds, 10);
      add_button = 1;
      for (int j = 1; j <= 20; j++) begin
         step();
         chk($sformatf("hold_step%0d", j), set_seconds,
             10 + int'(j >= 2) + int'(j >= 10) + int'(j >= 14) + int'(j >= 18));
      end
      add_button = 0;
      repeat (10) step();
      chk("hold_release", set_seconds, 14);

      // Full commit cycle with a one-cycle load strobe.
      do_reset();
      cur_hours = 5; cur_minutes = 6; cur_seconds = 7;
      repeat (3) press(1, 0, 0);
      chk("commit_pre_load", load_time, 0);
      cur_hours = 20; cur_minutes = 30; cur_seconds = 40;
      press(1, 0, 0);
      chk("commit_load", load_time, 1);
      chk("commit_run", run_enable, 1);
      chk("commit_set", {set_hours, set_minutes, set_seconds}, {5'd5, 6'd6, 6'd7});
      step();
      chk("commit_load_drop", load_time, 0);

      // Idle timeout in SET_MINUTES discards the edit.
      do_reset();
      cur_hours = 1; cur_minutes = 2; cur_seconds = 3;
      repeat (2) press(1, 0, 0);
      loads = 0;
      for (int k = 0; k < TOUT; k++) begin
         if (k == TOUT - 1) chk("tout_before", edit_field, 2);
         pulse_1hz = 1; step(); loads += int'(load_time);
         pulse_1hz = 0; step(); loads += int'(load_time);
         step(); loads += int'(load_time);
      end
      chk("tout_field", edit_field, 0);
      chk("tout_run", run_enable, 1);
      chk("tout_noload", loads, 0);
      chk("tout_set", {set_hours, set_minutes, set_seconds}, {5'd1, 6'd2, 6'd3});

      // Reset in the middle of an edit.
      do_reset();
      cur_hours = 9; cur_minutes = 8; cur_seconds = 7;
      press(1, 0, 0);
      press(0, 1, 0);
      chk("mid_hours", set_hours, 10);
      chk("mid_run", run_enable, 0);
      #2 reset = 0;
      #1;
      chk("mid_rst_run", run_enable, 1);
      chk("mid_rst_field", edit_field, 0);
      chk("mid_rst_load", load_time, 0);
      model_reset();
      @(posedge clock); #1 reset = 1;
      step(); step();
      chk("mid_after_load", load_time, 0);
      chk("mid_after_run", run_enable, 1);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         if (i % 128 == 0) busy = ($urandom_range(1) == 1);
         lim = busy ? 3 : 39;
         if ($urandom_range(lim) == 0) mode_button = ~mode_button;
         if ($urandom_range(lim) == 0) add_button  = ~add_button;
         if ($urandom_range(lim) == 0) sub_button  = ~sub_button;
         pulse_1hz   = ($urandom_range(5) == 0);
         cur_hours   = 5'($urandom_range(23));
         cur_minutes = 6'($urandom_range(59));
         cur_seconds = 6'($urandom_range(59));
         step();
         chk("rnd_run", run_enable, m_st == 0);
         chk("rnd_field", edit_field, m_st);
         chk("rnd_load", load_time, m_load);
         chk("rnd_h", set_hours, m_h);
         chk("rnd_m", set_minutes, m_mi);
         chk("rnd_s", set_seconds, m_s);
         chk("rnd_blink", blink_on, m_blink);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
